outlier_index_gen: RTL and testbench
====================================

Name: outlier_index_gen

Overview:
- Upstream producer of the per-lane permutation `index` consumed by the inlier segment. The inlier segment multiplies lanes index[NUM_LR..dimm-1]; the outlier path handles lanes index[0..NUM_LR-1].
- Takes one dimm-wide flt2int overflow vector per transaction and scans it SCAN_W lanes per clock.
- Builds a full permutation: outlier lanes first, inlier lanes after.
- Flags vectors whose outlier count exceeds the outlier path's capacity NUM_LR.

Parameters:
- dimm, 64: lanes per vector; must be a multiple of SCAN_W.
- NUM_LR, 4: outlier-path slots (slots 0..NUM_LR-1).
- SCAN_W, 8: lanes examined per SCAN cycle; must be a power of two.
- IndexWidth, $clog2(dimm): width of one index entry.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  overflow vector valid.
- in_ready  out  1  block can accept a vector.
- overflow  in  dimm  per-lane flag; 1 = lane's flt2int saturated (outlier).
- out_valid  out  1  index/num_outlier/excess valid.
- out_ready  in  1  consumer accepts the result.
- index  out  dimm*IndexWidth  permutation; slot s holds a lane number.
- num_outlier  out  IndexWidth+1  count of set overflow bits.
- excess  out  1  num_outlier > NUM_LR.
- excess_cnt  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, so in_ready = 1.
  - out_valid = 0, all index slots = 0, num_outlier = 0, excess = 0, excess_cnt = 0.
  - Captured vector and pointers cleared.
- FSM states IDLE, SCAN, DONE.
  - IDLE: in_ready = 1. On in_valid, latch overflow into a shadow register, set lane_ptr = 0, out_ptr = 0, in_ptr = dimm-1, then go to SCAN. The input vector may change after the accept edge.
  - SCAN: in_ready = 0; lasts exactly dimm/SCAN_W cycles. Each cycle, lanes lane_ptr..lane_ptr+SCAN_W-1 are processed in ascending order:
    - Outlier lane L: index[out_ptr] = L, then out_ptr++.
    - Inlier lane L: index[in_ptr] = L, then in_ptr--.
    - Pointer updates within a cycle are cumulative (prefix-count of flags in the group).
    - After the last group, go to DONE.
  - DONE: out_valid = 1 and num_outlier = out_ptr. When out_valid && out_ready, go to IDLE.
  - A new vector is never accepted in the same cycle as output handoff: in_ready only rises in IDLE, one cycle later.
- Result layout:
  - Slots 0..k-1 hold the outlier lanes in ascending order, where k = popcount.
  - Slots dimm-1 down to k hold the inlier lanes in ascending order, so the lowest inlier lane is in slot dimm-1.
  - The result is always a permutation of 0..dimm-1; every lane appears exactly once.
- excess = (k > NUM_LR). The excess outliers occupy slots NUM_LR..k-1, i.e. the inlier segment's range. The downstream consumer decides recovery.
- k < NUM_LR: slots k..NUM_LR-1 hold the highest-numbered inliers. This is legal; the outlier path computes them exactly.
- Output stability: index, num_outlier and excess update only during SCAN. They hold their values through DONE backpressure and into IDLE until the next accept.
- Throughput: one vector per dimm/SCAN_W + 2 cycles when out_ready is held at 1.
- Latency (defaults): out_valid rises 8 edges after the accepting edge.
- Reset mid-SCAN or mid-DONE: the transaction is abandoned, with no partial out_valid.

Optional Feature:
- Macro: OIG_EXCESS_CNT_EN.
- Defined: excess_cnt is a 16-bit counter. It increments by 1 on each output handshake with excess = 1, saturates at 16'hFFFF and is cleared only by rst.
- Undefined: the counter logic is absent and excess_cnt is tied to 0.

Test Plan (defaults dimm=64, NUM_LR=4, SCAN_W=8):
- overflow = all zeros -> after 8 edges out_valid = 1; index[s] = 63-s for all s; num_outlier = 0; excess = 0.
- overflow bits {3,17,40} set -> index[0..2] = 3,17,40; index[63] = 0, index[62] = 1, index[61] = 2, index[60] = 4; index[3] = 63; num_outlier = 3; excess = 0.
- overflow bits {0..5} set -> index[0..5] = 0..5; index[63] = 6; num_outlier = 6; excess = 1. With OIG_EXCESS_CNT_EN, excess_cnt goes 0 -> 1 at the handshake.
- overflow = all ones -> index[s] = s; num_outlier = 64; excess = 1.
- out_ready held 0 for 5 cycles in DONE, with in_valid pulsed meanwhile -> outputs stable, in_ready = 0, pulse ignored. out_ready = 1 -> IDLE next cycle, in_ready = 1.
- rst asserted in SCAN cycle 4 -> out_valid = 0 and in_ready = 1 immediately. Next vector {9} completes normally with index[0] = 9.

Source files
------------

// File: rtl/outlier_index_gen.sv
// Scans a dimm-wide overflow vector SCAN_W lanes per cycle and builds a lane permutation
// (outliers first, inliers last). Define OIG_EXCESS_CNT_EN to enable the excess_cnt counter.
module outlier_index_gen #(
    parameter int unsigned dimm       = 64,
    parameter int unsigned NUM_LR     = 4,
    parameter int unsigned SCAN_W     = 8,
    parameter int unsigned IndexWidth = $clog2(dimm)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [dimm-1:0]            overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [dimm*IndexWidth-1:0] index,
    output logic [IndexWidth:0]        num_outlier,
    output logic                       excess,
    output logic [15:0]                excess_cnt
);

    localparam int unsigned CntW = IndexWidth + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept_c;
    logic                  scan_c;
    logic                  handoff_c;
    logic [dimm-1:0]       shadow;
    logic [IndexWidth-1:0] lane_ptr;
    logic [CntW-1:0]       out_ptr;
    logic [CntW-1:0]       in_ptr;
    logic [CntW-1:0]       out_ptr_next_c;
    logic [CntW-1:0]       in_ptr_next_c;
    logic [IndexWidth-1:0] slot_c [SCAN_W];
    logic [IndexWidth-1:0] idx_q  [dimm];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        scan_c     = 1'b0;
        handoff_c  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                scan_c = 1'b1;
                if (lane_ptr == IndexWidth'(dimm - SCAN_W)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    handoff_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Destination slot of each lane in the current group: prefix counts of outliers/inliers
    always_comb begin
        out_ptr_next_c = out_ptr;
        in_ptr_next_c  = in_ptr;
        for (int j = 0; j < SCAN_W; j++) begin
            if (shadow[j]) begin
                slot_c[j]      = IndexWidth'(out_ptr_next_c);
                out_ptr_next_c = out_ptr_next_c + CntW'(1);
            end else begin
                slot_c[j]      = IndexWidth'(in_ptr_next_c);
                in_ptr_next_c  = in_ptr_next_c - CntW'(1);
            end
        end
    end

    // Shadow vector, pointers and the index table; results only change during SCAN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            lane_ptr    <= '0;
            out_ptr     <= '0;
            in_ptr      <= '0;
            num_outlier <= '0;
            excess      <= 1'b0;
            for (int s = 0; s < dimm; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            if (accept_c) begin
                shadow   <= overflow;
                lane_ptr <= '0;
                out_ptr  <= '0;
                in_ptr   <= CntW'(dimm - 1);
            end
            if (scan_c) begin
                shadow      <= shadow >> SCAN_W;
                lane_ptr    <= lane_ptr + IndexWidth'(SCAN_W);
                out_ptr     <= out_ptr_next_c;
                in_ptr      <= in_ptr_next_c;
                num_outlier <= out_ptr_next_c;
                excess      <= (out_ptr_next_c > CntW'(NUM_LR));
                for (int j = 0; j < SCAN_W; j++) begin
                    idx_q[slot_c[j]] <= lane_ptr + IndexWidth'(j);
                end
            end
        end
    end

    for (genvar s = 0; s < dimm; s++) begin : g_index
        assign index[s*IndexWidth +: IndexWidth] = idx_q[s];
    end

`ifdef OIG_EXCESS_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of handed-off vectors that overflowed the outlier path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (handoff_c && excess && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign excess_cnt = cnt_q;
`else
    assign excess_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_outlier_index_gen.sv
// Directed scoreboard bench for outlier_index_gen at default parameters.
module tb_outlier_index_gen;

    localparam int unsigned D   = 64;
    localparam int unsigned NLR = 4;
    localparam int unsigned SW  = 8;
    localparam int unsigned IW  = 6;
    localparam int unsigned CW  = 7;
    localparam int unsigned TW  = D * IW;

    typedef struct {
        logic [TW-1:0] idx;
        logic [CW-1:0] num;
        logic          exc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [D-1:0]  overflow = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] index;
    logic [CW-1:0] num_outlier;
    logic          excess;
    logic [15:0]   excess_cnt;

    int            total = 0;
    int            bad = 0;
    logic [15:0]   exp_cnt = '0;
    exp_t          sb[$];
    exp_t          cur;
    int            lat;

    always #5 clk = ~clk;

    outlier_index_gen #(.dimm(D), .NUM_LR(NLR), .SCAN_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .index(index), .num_outlier(num_outlier), .excess(excess),
        .excess_cnt(excess_cnt)
    );

    function automatic exp_t model(input logic [D-1:0] v);
        exp_t r;
        int   k  = 0;
        int   ni = 0;
        r.idx = '0;
        for (int l = 0; l < D; l++) begin
            if (v[l]) begin
                r.idx[k*IW +: IW] = IW'(l);
                k++;
            end else begin
                r.idx[(D-1-ni)*IW +: IW] = IW'(l);
                ni++;
            end
        end
        r.num = CW'(k);
        r.exc = (k > NLR);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [D-1:0] v, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", TW'(in_ready), TW'(1));
        in_valid = 1'b1;
        overflow = v;
        if (push) sb.push_back(model(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        overflow = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_rise", TW'(out_valid), TW'(1));
    endtask

    task automatic check_result(input string tag, output exp_t e);
        chk({tag, "_sb_nonempty"}, TW'(sb.size() > 0), TW'(1));
        if (sb.size() > 0) e = sb.pop_front();
        else e = model('0);
        chk({tag, "_index"}, index, e.idx);
        chk({tag, "_num"}, TW'(num_outlier), TW'(e.num));
        chk({tag, "_excess"}, TW'(excess), TW'(e.exc));
        chk({tag, "_in_ready_done"}, TW'(in_ready), TW'(0));
    endtask

    task automatic handshake(input string tag, input logic exc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`ifdef OIG_EXCESS_CNT_EN
        if (exc && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        chk({tag, "_cnt"}, TW'(excess_cnt), TW'(exp_cnt));
        chk({tag, "_idle_in_ready"}, TW'(in_ready), TW'(1));
        chk({tag, "_idle_out_valid"}, TW'(out_valid), TW'(0));
    endtask

    task automatic run_vec(input string tag, input logic [D-1:0] v);
        send(v, 1'b1);
        wait_out(lat);
        chk({tag, "_latency"}, TW'(lat), TW'(8));
        check_result(tag, cur);
        handshake(tag, cur.exc);
    endtask

    initial begin
        logic [D-1:0] v;

        // Reset state
        @(posedge clk); #1;
        chk("rst_in_ready", TW'(in_ready), TW'(1));
        chk("rst_out_valid", TW'(out_valid), TW'(0));
        chk("rst_index", index, TW'(0));
        chk("rst_num", TW'(num_outlier), TW'(0));
        chk("rst_excess", TW'(excess), TW'(0));
        chk("rst_cnt", TW'(excess_cnt), TW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // All inliers: reversed identity
        run_vec("zeros", '0);
        chk("zeros_slot0", TW'(index[0 +: IW]), TW'(63));
        chk("zeros_slot63", TW'(index[63*IW +: IW]), TW'(0));

        // Three outliers, fewer than NUM_LR
        v = '0; v[3] = 1'b1; v[17] = 1'b1; v[40] = 1'b1;
        run_vec("three", v);
        chk("three_slot2", TW'(index[2*IW +: IW]), TW'(40));
        chk("three_slot3", TW'(index[3*IW +: IW]), TW'(63));
        chk("three_slot60", TW'(index[60*IW +: IW]), TW'(4));
        chk("three_slot63", TW'(index[63*IW +: IW]), TW'(0));

        // Six outliers: excess
        v = 64'h3F;
        run_vec("six", v);
        chk("six_slot5", TW'(index[5*IW +: IW]), TW'(5));
        chk("six_slot63", TW'(index[63*IW +: IW]), TW'(6));
        chk("six_excess_const", TW'(excess), TW'(1));

        // All outliers: identity
        run_vec("ones", '1);
        chk("ones_num", TW'(num_outlier), TW'(64));
        chk("ones_slot63", TW'(index[63*IW +: IW]), TW'(63));

        // A few random vectors
        for (int r = 0; r < 4; r++) begin
            v = {$urandom, $urandom};
            if (r == 0) v = v & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            run_vec($sformatf("rand%0d", r), v);
        end

        // Backpressure in DONE with a stray in_valid pulse
        v = 64'h8000_0001_0010_0200;
        send(v, 1'b1);
        wait_out(lat);
        check_result("bp", cur);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid = 1'b1;
                overflow = '1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("bp_hold_valid%0d", c), TW'(out_valid), TW'(1));
            chk($sformatf("bp_hold_ready%0d", c), TW'(in_ready), TW'(0));
            chk($sformatf("bp_hold_index%0d", c), index, cur.idx);
            chk($sformatf("bp_hold_num%0d", c), TW'(num_outlier), TW'(cur.num));
        end
        handshake("bp", cur.exc);
        @(posedge clk); #1;
        chk("bp_idle_index", index, cur.idx);
        chk("bp_idle_num", TW'(num_outlier), TW'(cur.num));
        chk("bp_no_accept", TW'(out_valid), TW'(0));

        // Reset during SCAN cycle 4
        v = 64'hFFFF_0000_FFFF_0000;
        send(v, 1'b1);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", TW'(out_valid), TW'(0));
        chk("midrst_in_ready", TW'(in_ready), TW'(1));
        chk("midrst_num", TW'(num_outlier), TW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        chk("midrst_cnt", TW'(excess_cnt), TW'(0));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_quiet%0d", c), TW'(out_valid), TW'(0));
        end
        v = '0; v[9] = 1'b1;
        run_vec("after_rst", v);
        chk("after_rst_slot0", TW'(index[0 +: IW]), TW'(9));
        chk("sb_drained", TW'(sb.size()), TW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
